// File: rtl/eth_rx_frame_ctrl.sv
// eth_rx_frame_ctrl: read-side frame sequencer for the Ethernet RX buffer.
// Pops buffer words into a one-entry output register towards the uDMA RX
// channel, truncates frames at the programmed buffer size, and reports
// per-frame length / error / overflow with a one-cycle done pulse.
module eth_rx_frame_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_start_i,
  input  logic [LEN_W-1:0] cfg_size_i,
  input  logic             cfg_abort_i,
  input  logic [31:0]      s_data_i,
  input  logic [1:0]       s_byte_count_i,
  input  logic             s_last_i,
  input  logic             s_user_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [31:0]      udma_data_o,
  output logic             udma_valid_o,
  input  logic             udma_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] rx_len_o,
  output logic             err_user_o,
  output logic             err_ovf_o
);

  typedef enum logic [1:0] {IDLE, RUN, DROP, DONE} state_t;

  // Per-frame status snapshot, published at frame completion.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             user;
    logic             ovf;
  } status_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  status_t          acc_q, acc_d, stat_q;
  logic             got_q, got_d;   // at least one word accepted this frame
  logic             out_vld_q;
  logic [31:0]      out_data_q;

  logic             accept;
  logic             load_out;
  logic [2:0]       add_bytes;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_sat;
  logic [LEN_W:0]   size_p3;

  // ceil(size/4) via (size+3)>>2, widened so the +3 cannot wrap.
  assign size_p3   = {1'b0, cfg_size_i} + (LEN_W+1)'(3);

  // Byte count of a last word is 1..4 with 0 meaning 4; other words are full.
  assign add_bytes = (s_last_i && s_byte_count_i != 2'd0) ? {1'b0, s_byte_count_i} : 3'd4;
  assign len_sum   = {1'b0, acc_q.len} + (LEN_W+1)'(add_bytes);
  assign len_sat   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  // Pop strobe depends only on state and the output register, never on s_valid_i.
  always_comb begin
    s_ready_o = 1'b0;
    case (state_q)
      RUN:     s_ready_o = !out_vld_q || udma_ready_i;
      DROP:    s_ready_o = 1'b1;
      default: s_ready_o = 1'b0;
    endcase
  end

  assign accept   = s_valid_i && s_ready_o;
  assign load_out = accept && (state_q == RUN);

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    got_d   = got_q;
    case (state_q)
      IDLE: begin
        if (cfg_start_i && cfg_size_i != '0) begin
          rem_d   = LEN_W'(size_p3[LEN_W:2]);
          acc_d   = '0;
          got_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d.len  = len_sat;
          acc_d.user = acc_q.user | s_user_i;
          rem_d      = rem_q - LEN_W'(1);
          got_d      = 1'b1;
        end
        if (accept && s_last_i) begin
          // A simultaneous abort still marks the frame as truncated.
          if (cfg_abort_i) acc_d.ovf = 1'b1;
          state_d = DONE;
        end else if (accept && rem_q == LEN_W'(1)) begin
          acc_d.ovf = 1'b1;
          state_d   = DROP;
        end else if (cfg_abort_i) begin
          if (got_q || accept) begin
            acc_d.ovf = 1'b1;
            state_d   = DROP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept) begin
          acc_d.len  = len_sat;
          acc_d.user = acc_q.user | s_user_i;
          if (s_last_i) state_d = DONE;
        end
      end
      DONE: begin
        if (!out_vld_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame completes once the last forwarded word has left the output register.
  assign done_o = (state_q == DONE) && !out_vld_q;

  // Control state and accumulators.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      got_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      got_q   <= got_d;
    end
  end

  // One-entry output register; a held word stays until the uDMA takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (load_out) begin
      out_vld_q  <= 1'b1;
      out_data_q <= s_data_i;
    end else if (udma_ready_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  // Status holds until the next completed frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       stat_q <= '0;
    else if (done_o) stat_q <= acc_q;
  end

  assign udma_data_o  = out_data_q;
  assign udma_valid_o = out_vld_q;
  assign busy_o       = (state_q != IDLE);
  assign rx_len_o     = stat_q.len;
  assign err_user_o   = stat_q.user;
  assign err_ovf_o    = stat_q.ovf;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl: frame table plus hand sequences
// for abort-before-data, zero-size start and mid-frame reset.
module tb_eth_rx_frame_ctrl;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_abort;
  logic [LEN_W-1:0] cfg_size;
  logic [31:0]      s_data;
  logic [1:0]       s_bc;
  logic             s_last, s_user, s_valid, s_ready;
  logic [31:0]      udma_data;
  logic             udma_valid, udma_ready;
  logic             busy, done, err_user, err_ovf;
  logic [LEN_W-1:0] rx_len;

  always #5 clk = ~clk;

  eth_rx_frame_ctrl #(.LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_start_i(cfg_start), .cfg_size_i(cfg_size), .cfg_abort_i(cfg_abort),
    .s_data_i(s_data), .s_byte_count_i(s_bc), .s_last_i(s_last),
    .s_user_i(s_user), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .udma_data_o(udma_data), .udma_valid_o(udma_valid), .udma_ready_i(udma_ready),
    .busy_o(busy), .done_o(done), .rx_len_o(rx_len),
    .err_user_o(err_user), .err_ovf_o(err_ovf)
  );

  typedef struct {
    int size;       // cfg_size_i
    int nw;         // words in frame
    int bc;         // byte count on last word
    int user_w;     // word index carrying s_user_i, -1 none
    bit toggle;     // udma_ready_i alternates each cycle
    int abort_at;   // pulse abort once this many words accepted, -1 none
    int restart_at; // pulse a stray cfg_start once this many accepted, -1 none
    int exp_out;    // words forwarded to uDMA
    int exp_len;
    bit exp_u;
    bit exp_o;
  } vec_t;

  vec_t tbl [10];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int f, input int i);
    return {f[7:0], 8'hA5, i[15:0]};
  endfunction

  task automatic idle_inputs();
    cfg_start = 0; cfg_abort = 0; cfg_size = '0;
    s_valid = 0; s_data = '0; s_bc = '0; s_last = 0; s_user = 0;
    udma_ready = 1;
  endtask

  task automatic run_frame(input int f);
    vec_t v;
    int i, outc, dones, cyc, post;
    bit aborted, restarted, stall_prev;
    logic [31:0] prev_data;
    v = tbl[f];
    i = 0; outc = 0; dones = 0; cyc = 0; post = 0;
    aborted = 0; restarted = 0; stall_prev = 0; prev_data = '0;
    @(negedge clk);
    cfg_start = 1; cfg_size = LEN_W'(v.size); udma_ready = 1;
    @(negedge clk);
    while (cyc < 400) begin
      cfg_start = 0; cfg_abort = 0;
      udma_ready = v.toggle ? cyc[0] : 1'b1;
      if (v.abort_at >= 0 && !aborted && i == v.abort_at) begin
        cfg_abort = 1; aborted = 1; s_valid = 0;
      end else begin
        s_valid = (i < v.nw);
      end
      if (v.restart_at >= 0 && !restarted && i == v.restart_at) begin
        cfg_start = 1; cfg_size = LEN_W'(4); restarted = 1;
      end
      s_data = word(f, i);
      s_last = (i == v.nw - 1);
      s_bc   = (i == v.nw - 1) ? 2'(v.bc) : 2'd1;
      s_user = (i == v.user_w);
      #1;
      if (cyc == 0) chk("busy_rise", busy, 1);
      if (stall_prev) chk("stall_data", udma_data, prev_data);
      if (udma_valid && !udma_ready) chk("sready_stall", s_ready, 0);
      if (udma_valid && udma_ready) begin
        chk("out_data", udma_data, word(f, outc));
        outc++;
      end
      stall_prev = udma_valid && !udma_ready;
      prev_data  = udma_data;
      if (s_valid && s_ready) i++;
      if (done) dones++;
      if (dones > 0) post++;
      cyc++;
      if (post >= 3) break;
      @(negedge clk);
    end
    idle_inputs();
    chk("out_cnt", outc, v.exp_out);
    chk("done_cnt", dones, 1);
    chk("rx_len", rx_len, v.exp_len);
    chk("err_user", err_user, v.exp_u);
    chk("err_ovf", err_ovf, v.exp_o);
    chk("busy_fall", busy, 0);
  endtask

  initial begin
    //          size nw bc user tog abort rst  out len  u  o
    tbl[0] = '{64, 16, 0, -1, 0, -1, -1, 16, 64, 0, 0};  // aligned
    tbl[1] = '{64,  3, 2, -1, 0, -1, -1,  3, 10, 0, 0};  // partial last
    tbl[2] = '{ 8,  5, 0, -1, 0, -1, -1,  2, 20, 0, 1};  // overflow
    tbl[3] = '{64,  8, 3, -1, 1, -1, -1,  8, 31, 0, 0};  // backpressure
    tbl[4] = '{64,  4, 1,  2, 0, -1, -1,  4, 13, 1, 0};  // user error
    tbl[5] = '{64,  5, 0, -1, 0,  1, -1,  1, 20, 0, 1};  // abort after 1
    tbl[6] = '{12,  3, 0, -1, 0, -1, -1,  3, 12, 0, 0};  // exact fit
    tbl[7] = '{10,  3, 2, -1, 0, -1, -1,  3, 10, 0, 0};  // size not /4
    tbl[8] = '{10,  4, 1, -1, 0, -1, -1,  3, 13, 0, 1};  // 1 word over
    tbl[9] = '{64,  6, 0, -1, 0, -1,  1,  6, 24, 0, 0};  // start in RUN

    idle_inputs();
    rst = 1;
    #1;
    chk("rst_sready", s_ready, 0);
    chk("rst_uvalid", udma_valid, 0);
    chk("rst_udata", udma_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len", rx_len, 0);
    chk("rst_euser", err_user, 0);
    chk("rst_eovf", err_ovf, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    for (int f = 0; f < 10; f++) run_frame(f);

    // Zero-size start is ignored.
    @(negedge clk);
    cfg_start = 1; cfg_size = '0;
    @(negedge clk);
    cfg_start = 0;
    #1 chk("size0_busy", busy, 0);

    // Abort before any word: back to IDLE, no done, status from last frame.
    @(negedge clk);
    cfg_start = 1; cfg_size = LEN_W'(64);
    @(negedge clk);
    cfg_start = 0; cfg_abort = 1;
    #1 chk("abort0_busy1", busy, 1);
    @(negedge clk);
    cfg_abort = 0;
    #1;
    chk("abort0_busy0", busy, 0);
    chk("abort0_done", done, 0);
    chk("abort0_len", rx_len, 24);
    @(negedge clk);
    #1 chk("abort0_done2", done, 0);

    // Reset mid-frame with a word stuck in the output register.
    @(negedge clk);
    cfg_start = 1; cfg_size = LEN_W'(64); udma_ready = 0;
    @(negedge clk);
    cfg_start = 0; s_valid = 1; s_data = 32'hDEADBEEF;
    @(negedge clk);
    s_data = 32'hCAFEF00D;
    #1 chk("mid_uvalid", udma_valid, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mr_uvalid", udma_valid, 0);
    chk("mr_udata", udma_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_sready", s_ready, 0);
    chk("mr_len", rx_len, 0);
    chk("mr_eovf", err_ovf, 0);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
